// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the multicycle RV32I-subset core control path:
//   FSM state encoding, the opcodes the control FSM recognises, the ALUOp
//   codes handed to alucontrol, the ALU operand-select codes and the bundle
//   of datapath control signals produced each cycle.
// ---------------------------------------------------------------------------
package core_pkg;

  // Control FSM states.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_EXECUTE,
    ST_ALU_WB,
    ST_BRANCH,
    ST_TRAP
  } state_e;

  // Recognised opcodes (IR[6:0]).
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALUOp codes consumed by alucontrol. 2'b11 is never produced.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand A select.
  localparam logic SRCA_PC  = 1'b0;
  localparam logic SRCA_RS1 = 1'b1;

  // ALU operand B select.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Everything the FSM drives into the datapath and memory in one cycle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal_instr;
  } ctrl_t;

  // All-inactive control word: what IDLE, reset and unlisted outputs show.
  localparam ctrl_t CTRL_NONE = '0;

  // True for the opcodes that go through the address-calculation state.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// ---------------------------------------------------------------------------
// retire_counter
//   Counts retired instructions. Increments by one on every clock where
//   inc_i is high and wraps from all-ones back to zero.
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset, clears the count
//   inc_i    in   one-cycle retire pulse
//   count_o  out  CNT_W-bit running count
// ---------------------------------------------------------------------------
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Natural modulo-2^CNT_W wrap: no saturation logic wanted.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multicycle RV32I-subset core. Steps each
//   instruction through fetch/decode/execute/memory/writeback, drives the
//   datapath muxes and enables, produces ALUOp for alucontrol, handshakes
//   with the shared instruction/data memory, counts retired instructions
//   and traps on illegal opcodes.
// Parameters
//   CNT_W            width of the retired-instruction counter
//   TRAP_ON_ILLEGAL  1: illegal opcode enters sticky TRAP; 0: retired as NOP
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   opcode           IR[6:0]
//   mem_ready        memory completes the current request this cycle
//   mem_req/mem_write/iord        memory request, direction, address select
//   ir_write/pc_write/pc_write_cond/pc_source   IR and PC update controls
//   alu_src_a/alu_src_b/alu_op    ALU operand selects and ALUOp
//   reg_write/mem_to_reg          register file write enable and source
//   instr_done       one-cycle pulse per retired instruction
//   retired          retired-instruction count
//   illegal_instr    sticky trap flag
// ---------------------------------------------------------------------------
module multicycle_control
  import core_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal_instr
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  // -------------------------------------------------------------------------
  // State register. Every output is decoded from state_q (plus mem_ready in
  // the wait states), so forcing IDLE on reset forces every output to zero
  // immediately, without waiting for a clock.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; a blocking
      // assignment here would create simulation order races.
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and control decode.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so every path assigns every bit; otherwise the
    // unassigned bits would infer latches.
    state_d = state_q;
    ctrl    = CTRL_NONE;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      // Read the instruction at PC and compute PC+4 in parallel. IR and PC
      // are loaded only on the cycle the memory actually answers.
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = ST_DECODE;
        end
      end

      // PC + immediate goes into ALUOut so BRANCH can use it as the target.
      ST_DECODE: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        if (is_mem_op(opcode)) begin
          state_d = ST_MEM_ADR;
        end else if (opcode == OP_R) begin
          state_d = ST_EXECUTE;
        end else if (opcode == OP_BEQ) begin
          state_d = ST_BRANCH;
        end else if (TRAP_ON_ILLEGAL != 0) begin
          state_d = ST_TRAP;
        end else begin
          // Unknown opcode retires as a NOP straight out of decode.
          ctrl.instr_done = 1'b1;
          state_d         = ST_FETCH;
        end
      end

      // rs1 + offset. IR cannot change outside FETCH, so the opcode seen
      // here is the one decoded a cycle earlier.
      ST_MEM_ADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end

      ST_MEM_READ: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) begin
          state_d = ST_MEM_WB;
        end
      end

      // A store has nothing to write back, so it retires on the cycle the
      // memory accepts the write.
      ST_MEM_WRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_d         = ST_FETCH;
        end
      end

      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = ST_FETCH;
      end

      ST_EXECUTE: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = ST_ALU_WB;
      end

      ST_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
        state_d         = ST_FETCH;
      end

      // rs1 - rs2 sets the ALU zero flag; the datapath loads PC from the
      // precomputed target in ALUOut only when zero is set.
      ST_BRANCH: begin
        ctrl.alu_src_a     = SRCA_RS1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.instr_done    = 1'b1;
        state_d            = ST_FETCH;
      end

      // Sticky: only reset leaves TRAP.
      ST_TRAP: begin
        ctrl.illegal_instr = 1'b1;
        state_d            = ST_TRAP;
      end

      // Unused encodings recover through IDLE.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Retire counter.
  // -------------------------------------------------------------------------
  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (ctrl.instr_done),
    .count_o (retired)
  );

  // -------------------------------------------------------------------------
  // Output mapping.
  // -------------------------------------------------------------------------
  assign mem_req       = ctrl.mem_req;
  assign mem_write     = ctrl.mem_write;
  assign iord          = ctrl.iord;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign instr_done    = ctrl.instr_done;
  assign illegal_instr = ctrl.illegal_instr;

  // -------------------------------------------------------------------------
  // Interface invariants.
  // -------------------------------------------------------------------------
  a_alu_op_legal : assert property (@(posedge clk) disable iff (!rst_n)
    alu_op != 2'b11);

  a_req_held : assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req && !mem_ready) |=> (mem_req && $stable(iord) && $stable(mem_write)));

  a_trap_sticky : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_TRAP) |=> (state_q == ST_TRAP));

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Two instances share one stimulus stream:
//     dut_a : CNT_W=32, TRAP_ON_ILLEGAL=1
//     dut_b : CNT_W=4,  TRAP_ON_ILLEGAL=0
//   The reference model works per instruction: from the opcode and the
//   number of memory wait cycles it lists the expected control word for
//   each cycle of that instruction, and keeps a retired count per instance.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  // Expected/observed control word, one bit per output port.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal_instr;
  } ctl_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // Per-step control words taken from the behaviour table.
  localparam ctl_t W_NONE    = '0;
  localparam ctl_t W_FETCH   = '{mem_req: 1'b1, alu_src_b: 2'b01, default: '0};
  localparam ctl_t W_FETCHED = '{mem_req: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1,
                                 pc_write: 1'b1, default: '0};
  localparam ctl_t W_DECODE  = '{alu_src_b: 2'b10, default: '0};
  localparam ctl_t W_NOP     = '{alu_src_b: 2'b10, instr_done: 1'b1, default: '0};
  localparam ctl_t W_MEM_ADR = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam ctl_t W_MEM_RD  = '{mem_req: 1'b1, iord: 1'b1, default: '0};
  localparam ctl_t W_MEM_WR  = '{mem_req: 1'b1, mem_write: 1'b1, iord: 1'b1, default: '0};
  localparam ctl_t W_MEM_WRD = '{mem_req: 1'b1, mem_write: 1'b1, iord: 1'b1,
                                 instr_done: 1'b1, default: '0};
  localparam ctl_t W_MEM_WB  = '{reg_write: 1'b1, mem_to_reg: 1'b1, instr_done: 1'b1,
                                 default: '0};
  localparam ctl_t W_EXEC    = '{alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
  localparam ctl_t W_ALU_WB  = '{reg_write: 1'b1, instr_done: 1'b1, default: '0};
  localparam ctl_t W_BRANCH  = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_write_cond: 1'b1,
                                 pc_source: 1'b1, instr_done: 1'b1, default: '0};
  localparam ctl_t W_TRAP    = '{illegal_instr: 1'b1, default: '0};

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;

  logic        mem_req_a, mem_write_a, iord_a, ir_write_a, pc_write_a;
  logic        pc_write_cond_a, pc_source_a, alu_src_a_a;
  logic [1:0]  alu_src_b_a, alu_op_a;
  logic        reg_write_a, mem_to_reg_a, instr_done_a, illegal_instr_a;
  logic [31:0] retired_a;

  logic        mem_req_b, mem_write_b, iord_b, ir_write_b, pc_write_b;
  logic        pc_write_cond_b, pc_source_b, alu_src_a_b;
  logic [1:0]  alu_src_b_b, alu_op_b;
  logic        reg_write_b, mem_to_reg_b, instr_done_b, illegal_instr_b;
  logic [3:0]  retired_b;

  ctl_t act_a;
  ctl_t act_b;

  assign act_a = {mem_req_a, mem_write_a, iord_a, ir_write_a, pc_write_a,
                  pc_write_cond_a, pc_source_a, alu_src_a_a, alu_src_b_a,
                  alu_op_a, reg_write_a, mem_to_reg_a, instr_done_a,
                  illegal_instr_a};
  assign act_b = {mem_req_b, mem_write_b, iord_b, ir_write_b, pc_write_b,
                  pc_write_cond_b, pc_source_b, alu_src_a_b, alu_src_b_b,
                  alu_op_b, reg_write_b, mem_to_reg_b, instr_done_b,
                  illegal_instr_b};

  multicycle_control #(
    .CNT_W           (32),
    .TRAP_ON_ILLEGAL (1)
  ) dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req_a),
    .mem_write     (mem_write_a),
    .iord          (iord_a),
    .ir_write      (ir_write_a),
    .pc_write      (pc_write_a),
    .pc_write_cond (pc_write_cond_a),
    .pc_source     (pc_source_a),
    .alu_src_a     (alu_src_a_a),
    .alu_src_b     (alu_src_b_a),
    .alu_op        (alu_op_a),
    .reg_write     (reg_write_a),
    .mem_to_reg    (mem_to_reg_a),
    .instr_done    (instr_done_a),
    .retired       (retired_a),
    .illegal_instr (illegal_instr_a)
  );

  multicycle_control #(
    .CNT_W           (4),
    .TRAP_ON_ILLEGAL (0)
  ) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req_b),
    .mem_write     (mem_write_b),
    .iord          (iord_b),
    .ir_write      (ir_write_b),
    .pc_write      (pc_write_b),
    .pc_write_cond (pc_write_cond_b),
    .pc_source     (pc_source_b),
    .alu_src_a     (alu_src_a_b),
    .alu_src_b     (alu_src_b_b),
    .alu_op        (alu_op_b),
    .reg_write     (reg_write_b),
    .mem_to_reg    (mem_to_reg_b),
    .instr_done    (instr_done_b),
    .retired       (retired_b),
    .illegal_instr (illegal_instr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cnt_a;   // model: retired count of dut_a
  logic [3:0]  cnt_b;   // model: retired count of dut_b, wraps at 16

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] junk_op();
    return 7'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the model's retire counts by what this cycle should retire.
  task automatic step(input string tag, input ctl_t ea, input ctl_t eb, input bit chk_b,
                      input logic rdy, input logic [6:0] op);
    opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
    check({tag, " ctl_a"}, {16'h0, act_a}, {16'h0, ea});
    check({tag, " retired_a"}, retired_a, cnt_a);
    if (chk_b) begin
      check({tag, " ctl_b"}, {16'h0, act_b}, {16'h0, eb});
      check({tag, " retired_b"}, {28'h0, retired_b}, {28'h0, cnt_b});
    end
    if (ea.instr_done) cnt_a = cnt_a + 32'd1;
    if (chk_b && eb.instr_done) cnt_b = cnt_b + 4'd1;
    @(posedge clk);
    #1;
  endtask

  // Both instances must show all-zero outputs and a cleared count.
  task automatic check_all_zero(input string tag);
    check({tag, " ctl_a"}, {16'h0, act_a}, {16'h0, W_NONE});
    check({tag, " retired_a"}, retired_a, 32'd0);
    check({tag, " ctl_b"}, {16'h0, act_b}, {16'h0, W_NONE});
    check({tag, " retired_b"}, {28'h0, retired_b}, 32'd0);
  endtask

  // Wait cycles in a memory state: request held, no ready.
  task automatic mem_wait(input string tag, input ctl_t w, input int n, input logic [6:0] op);
    for (int i = 0; i < n; i++) step(tag, w, w, 1'b1, 1'b0, op);
  endtask

  // Whole instruction: fw wait cycles in FETCH, mw wait cycles in the data
  // memory state (if any). mem_ready is random wherever no request is out.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    mem_wait("fetch wait", W_FETCH, fw, junk_op());
    step("fetch", W_FETCHED, W_FETCHED, 1'b1, 1'b1, junk_op());
    case (op)
      LW: begin
        step("lw decode", W_DECODE, W_DECODE, 1'b1, rnd_bit(), op);
        step("lw adr", W_MEM_ADR, W_MEM_ADR, 1'b1, rnd_bit(), op);
        mem_wait("lw read wait", W_MEM_RD, mw, op);
        step("lw read", W_MEM_RD, W_MEM_RD, 1'b1, 1'b1, op);
        step("lw wb", W_MEM_WB, W_MEM_WB, 1'b1, rnd_bit(), op);
      end
      SW: begin
        step("sw decode", W_DECODE, W_DECODE, 1'b1, rnd_bit(), op);
        step("sw adr", W_MEM_ADR, W_MEM_ADR, 1'b1, rnd_bit(), op);
        mem_wait("sw write wait", W_MEM_WR, mw, op);
        step("sw write", W_MEM_WRD, W_MEM_WRD, 1'b1, 1'b1, op);
      end
      RT: begin
        step("r decode", W_DECODE, W_DECODE, 1'b1, rnd_bit(), op);
        step("r exec", W_EXEC, W_EXEC, 1'b1, rnd_bit(), op);
        step("r wb", W_ALU_WB, W_ALU_WB, 1'b1, rnd_bit(), op);
      end
      BEQ: begin
        step("beq decode", W_DECODE, W_DECODE, 1'b1, rnd_bit(), op);
        step("beq branch", W_BRANCH, W_BRANCH, 1'b1, rnd_bit(), op);
      end
      default: begin
        // dut_a traps; dut_b retires a NOP and starts the next fetch.
        step("illegal decode", W_DECODE, W_NOP, 1'b1, rnd_bit(), op);
        step("trap enter", W_TRAP, W_FETCH, 1'b1, 1'b0, op);
        for (int i = 0; i < 6; i++) step("trap stay", W_TRAP, W_NONE, 1'b0, rnd_bit(), junk_op());
      end
    endcase
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    cnt_a = '0;
    cnt_b = '0;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle", W_NONE, W_NONE, 1'b1, rnd_bit(), junk_op());
  endtask

  logic [6:0] legal_ops [4];

  initial begin
    legal_ops[0] = LW;
    legal_ops[1] = SW;
    legal_ops[2] = RT;
    legal_ops[3] = BEQ;

    rst_n     = 1'b0;
    opcode    = 7'h00;
    mem_ready = 1'b1;   // ignored while in reset
    cnt_a     = '0;
    cnt_b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("power-on reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle", W_NONE, W_NONE, 1'b1, 1'b1, junk_op());

    // Directed cases from the behaviour description.
    run_instr(RT, 0, 0);
    run_instr(LW, 2, 3);     // retires on cycle 10
    run_instr(BEQ, 0, 0);
    run_instr(SW, 0, 0);
    run_instr(SW, 1, 2);
    run_instr(LW, 0, 0);

    // Random legal instruction stream with random wait states.
    for (int n = 0; n < 80; n++) begin
      run_instr(legal_ops[$urandom_range(0, 3)], $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Illegal opcode: sticky trap on dut_a, 2-cycle NOP on dut_b.
    run_instr(BAD, 0, 0);
    apply_reset();

    // Reset while a load is waiting in MEM_READ with its request out.
    run_instr(RT, 0, 0);
    step("rst fetch", W_FETCHED, W_FETCHED, 1'b1, 1'b1, junk_op());
    step("rst decode", W_DECODE, W_DECODE, 1'b1, 1'b0, LW);
    step("rst adr", W_MEM_ADR, W_MEM_ADR, 1'b1, 1'b0, LW);
    step("rst read wait", W_MEM_RD, W_MEM_RD, 1'b1, 1'b0, LW);
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    cnt_a = '0;
    cnt_b = '0;
    check_all_zero("async reset in mem_read");
    @(posedge clk);
    #1;
    check_all_zero("held reset");
    rst_n = 1'b1;
    step("idle after reset", W_NONE, W_NONE, 1'b1, 1'b1, junk_op());

    // 16 retires: the 4-bit counter wraps back to zero.
    for (int n = 0; n < 16; n++) run_instr(RT, 0, 0);
    @(negedge clk);
    check("wrap retired_b", {28'h0, retired_b}, 32'd0);
    check("wrap retired_a", retired_a, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
